uart_receiver: RTL and testbench

- Serial-to-parallel UART receiver. It is the receive end of the existing Control_Unit/Datapath_Unit transmitter.
- Frame format: idle high, 1 start bit (0), WORD_SIZE data bits LSB first, 1 stop bit (1).
- Samples Serial_in with a local clock running at SAMPLES_PER_BIT times the bit rate.
- Hands each received word to the host through a ready flag and acknowledge handshake, with overrun and framing error flags.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_rx_bit_timer.sv | 74 +++++++
 rtl/uart_receiver.sv | 98 +++++++++
 tb/tb_uart_receiver.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path.
// Contents:
//   - Default word size and sample rate.
//   - Line levels for the start and stop bits.
//   - The receiver FSM state encoding. It is kept apart from the transmitter
//     state types so that the two state machines can evolve independently.
package uart_pkg;

  localparam int WORD_SIZE_DEF       = 8;
  localparam int SAMPLES_PER_BIT_DEF = 8;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    STARTING  = 2'd1,
    RECEIVING = 2'd2
  } rx_state_t;

endpackage

// File: rtl/uart_rx_bit_timer.sv
// Bit timing for the UART receiver.
// This block owns the sample counter and the bit counter. It decodes them
// into single-cycle strobes that tell the FSM when to sample Serial_in.
// Ports:
//   Clock        system clock, rising edge
//   rst_b        asynchronous active-low reset
//   state        current receiver FSM state
//   mid_start    strobe: the middle of the start bit is at this edge
//   sample_data  strobe: the middle of a data bit is at this edge
//   sample_stop  strobe: the middle of the stop bit is at this edge
module uart_rx_bit_timer
  import uart_pkg::*;
#(
  parameter int WORD_SIZE       = WORD_SIZE_DEF,
  parameter int SAMPLES_PER_BIT = SAMPLES_PER_BIT_DEF
) (
  input  logic      Clock,
  input  logic      rst_b,
  input  rx_state_t state,
  output logic      mid_start,
  output logic      sample_data,
  output logic      sample_stop
);

  localparam int SC_W = $clog2(SAMPLES_PER_BIT);
  localparam int BC_W = $clog2(WORD_SIZE + 2);

  // The counter holds the number of edges already spent in the current
  // phase. The strobe therefore fires when the count is one below the
  // target distance.
  localparam logic [SC_W-1:0] HALF_LAST = SC_W'(SAMPLES_PER_BIT / 2 - 1);
  localparam logic [SC_W-1:0] BIT_LAST  = SC_W'(SAMPLES_PER_BIT - 1);
  localparam logic [BC_W-1:0] STOP_IDX  = BC_W'(WORD_SIZE);

  logic [SC_W-1:0] sample_cnt;
  logic [BC_W-1:0] bit_cnt;
  logic            bit_point;

  assign bit_point   = (state == RECEIVING) && (sample_cnt == BIT_LAST);
  assign mid_start   = (state == STARTING) && (sample_cnt == HALF_LAST);
  assign sample_data = bit_point && (bit_cnt != STOP_IDX);
  assign sample_stop = bit_point && (bit_cnt == STOP_IDX);

  always_ff @(posedge Clock or negedge rst_b) begin
    if (!rst_b) begin
      sample_cnt <= '0;
      bit_cnt    <= '0;
    end else begin
      case (state)
        STARTING: begin
          if (mid_start) begin
            sample_cnt <= '0;
            bit_cnt    <= '0;
          end else begin
            sample_cnt <= sample_cnt + 1'b1;
          end
        end
        RECEIVING: begin
          if (bit_point) begin
            sample_cnt <= '0;
            if (sample_data) bit_cnt <= bit_cnt + 1'b1;
          end else begin
            sample_cnt <= sample_cnt + 1'b1;
          end
        end
        default: begin
          sample_cnt <= '0;
          bit_cnt    <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// Serial-to-parallel UART receiver.
// Frame: idle high, one start bit (0), WORD_SIZE data bits LSB first, and
// one stop bit (1). The line is sampled at the middle of each bit.
// Ports:
//   Clock               system clock, rising edge
//   rst_b               asynchronous active-low reset
//   Serial_in           serial line, idle high, synchronous to Clock
//   read_not_ready_in   host acknowledge, 1-cycle pulse
//   RCV_datareg         last delivered word
//   read_not_ready_out  1 while RCV_datareg holds an unread word
//   Error1              overrun: a frame ended while a word was still unread
//   Error2              framing: the stop bit was sampled low
module uart_receiver
  import uart_pkg::*;
#(
  parameter int WORD_SIZE       = WORD_SIZE_DEF,
  parameter int SAMPLES_PER_BIT = SAMPLES_PER_BIT_DEF
) (
  input  logic                 Clock,
  input  logic                 rst_b,
  input  logic                 Serial_in,
  input  logic                 read_not_ready_in,
  output logic [WORD_SIZE-1:0] RCV_datareg,
  output logic                 read_not_ready_out,
  output logic                 Error1,
  output logic                 Error2
);

  rx_state_t            state;
  logic [WORD_SIZE-1:0] shift_reg;
  logic                 mid_start;
  logic                 sample_data;
  logic                 sample_stop;
  logic                 ack_vld;
  logic                 overrun;

  uart_rx_bit_timer #(
    .WORD_SIZE      (WORD_SIZE),
    .SAMPLES_PER_BIT(SAMPLES_PER_BIT)
  ) u_bit_timer (
    .Clock      (Clock),
    .rst_b      (rst_b),
    .state      (state),
    .mid_start  (mid_start),
    .sample_data(sample_data),
    .sample_stop(sample_stop)
  );

  // An acknowledge only counts while a word is pending. An overrun is a stop
  // sample that arrives while the host has neither read nor acknowledged the
  // pending word.
  assign ack_vld = read_not_ready_in && read_not_ready_out;
  assign overrun = read_not_ready_out && !read_not_ready_in;

  always_ff @(posedge Clock or negedge rst_b) begin
    if (!rst_b) begin
      state              <= IDLE;
      shift_reg          <= '0;
      RCV_datareg        <= '0;
      read_not_ready_out <= 1'b0;
      Error1             <= 1'b0;
      Error2             <= 1'b0;
    end else begin
      // The acknowledge clears the flags first. A stop sample on the same
      // edge then overrides these clears with the new frame's result.
      if (ack_vld) begin
        read_not_ready_out <= 1'b0;
        Error1             <= 1'b0;
        Error2             <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (Serial_in == START_BIT) state <= STARTING;
        end
        STARTING: begin
          // A line that is high again by mid-bit was a glitch, not a start.
          if (mid_start) state <= (Serial_in == START_BIT) ? RECEIVING : IDLE;
        end
        RECEIVING: begin
          if (sample_data) shift_reg <= {Serial_in, shift_reg[WORD_SIZE-1:1]};
          if (sample_stop) begin
            state <= IDLE;
            if (overrun) begin
              Error1 <= 1'b1;
            end else begin
              RCV_datareg        <= shift_reg;
              read_not_ready_out <= 1'b1;
            end
            if (Serial_in != STOP_BIT) Error2 <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver.
// It runs a table of directed frames, hand-built glitch and reset sequences,
// and randomized frames. The randomized frames are checked against a
// frame-level model of the receiver outputs.
module tb_uart_receiver;
  import uart_pkg::*;

  localparam int W = 8;
  localparam int S = 8;
  localparam int STOP_N = (W + 1) * S + S / 2;  // stop-sample edge offset from start edge

  logic         clk = 1'b0;
  logic         rst_b;
  logic         ser;
  logic         ack;
  logic [W-1:0] rdata;
  logic         rnr;
  logic         e1;
  logic         e2;

  int checks   = 0;
  int failures = 0;

  // Frame-level model of the host-visible outputs.
  logic [W-1:0] m_data;
  logic         m_rnr;
  logic         m_e1;
  logic         m_e2;

  typedef struct {
    logic [W-1:0] data;
    logic         stopv;
    logic         ack_stop;
    logic         ack_after;
    logic         glitch_before;
    logic [W-1:0] exp_data;
    logic         exp_rnr;
    logic         exp_e1;
    logic         exp_e2;
  } vec_t;

  vec_t tbl[6];

  always #5 clk = ~clk;

  uart_receiver #(
    .WORD_SIZE      (W),
    .SAMPLES_PER_BIT(S)
  ) dut (
    .Clock             (clk),
    .rst_b             (rst_b),
    .Serial_in         (ser),
    .read_not_ready_in (ack),
    .RCV_datareg       (rdata),
    .read_not_ready_out(rnr),
    .Error1            (e1),
    .Error2            (e2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [W-1:0] d, input logic r,
                           input logic a, input logic b);
    check({tag, " data"}, 32'(rdata), 32'(d));
    check({tag, " ready"}, 32'(rnr), 32'(r));
    check({tag, " err1"}, 32'(e1), 32'(a));
    check({tag, " err2"}, 32'(e2), 32'(b));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      ser = 1'b1;
      ack = 1'b0;
    end
  endtask

  task automatic pulse_ack;
    @(negedge clk);
    ser = 1'b1;
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask

  // Drives one complete frame. The first start-bit edge comes right after the
  // first negedge. With ack_stop set, the acknowledge is pulsed on the
  // stop-sample edge. With chk_lat set, read_not_ready_out is checked on both
  // sides of that edge.
  task automatic send_frame(input logic [W-1:0] d, input logic stopv, input logic ack_stop,
                            input logic chk_lat);
    logic [W+1:0] bits;
    bits = {stopv, d, START_BIT};
    for (int b = 0; b < W + 2; b++) begin
      for (int c = 0; c < S; c++) begin
        @(negedge clk);
        if (chk_lat && (b * S + c == STOP_N)) check("latency before", 32'(rnr), 32'd0);
        if (chk_lat && (b * S + c == STOP_N + 1)) check("latency at", 32'(rnr), 32'd1);
        ser = bits[b];
        ack = ack_stop && (b == W + 1) && (c == S / 2);
      end
    end
  endtask

  task automatic model_frame(input logic [W-1:0] d, input logic stopv, input logic ack_stop);
    if (ack_stop && m_rnr) begin
      m_rnr = 1'b0;
      m_e1  = 1'b0;
      m_e2  = 1'b0;
    end
    if (m_rnr) m_e1 = 1'b1;
    else begin
      m_data = d;
      m_rnr  = 1'b1;
    end
    if (!stopv) m_e2 = 1'b1;
  endtask

  task automatic model_ack;
    if (m_rnr) begin
      m_rnr = 1'b0;
      m_e1  = 1'b0;
      m_e2  = 1'b0;
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] d;
    logic         stopv, ack_stop, ack_after;
    logic [W+1:0] ff_bits;

    // data, stop, ack_stop, ack_after, glitch_before, exp_data, rnr, e1, e2
    tbl[0] = '{8'hA7, 1'b1, 1'b0, 1'b1, 1'b0, 8'hA7, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{8'h3C, 1'b0, 1'b0, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b1};
    tbl[2] = '{8'h55, 1'b1, 1'b0, 1'b0, 1'b0, 8'h55, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{8'hAA, 1'b1, 1'b0, 1'b1, 1'b0, 8'h55, 1'b1, 1'b1, 1'b0};
    tbl[4] = '{8'h55, 1'b1, 1'b0, 1'b0, 1'b0, 8'h55, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{8'hAA, 1'b1, 1'b1, 1'b1, 1'b0, 8'hAA, 1'b1, 1'b0, 1'b0};

    // Reset with a toggling line.
    rst_b = 1'b0;
    ser   = 1'b1;
    ack   = 1'b0;
    repeat (3) begin
      @(negedge clk);
      ser = ~ser;
    end
    check_out("reset", 8'h00, 1'b0, 1'b0, 1'b0);
    check("reset state", 32'(dut.state), 32'(IDLE));
    @(negedge clk);
    rst_b = 1'b1;
    ser   = 1'b1;
    idle(10);
    check_out("post reset idle", 8'h00, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 6; i++) begin
      if (tbl[i].glitch_before) begin
        @(negedge clk);
        ser = 1'b0;
        @(negedge clk);
        ser = 1'b0;
        idle(10);
        check("glitch state", 32'(dut.state), 32'(IDLE));
        check("glitch ready", 32'(rnr), 32'd0);
        check("glitch data", 32'(rdata), 32'(8'hA7));
      end
      send_frame(tbl[i].data, tbl[i].stopv, tbl[i].ack_stop, i == 0);
      check_out($sformatf("vec%0d", i), tbl[i].exp_data, tbl[i].exp_rnr, tbl[i].exp_e1,
                tbl[i].exp_e2);
      if (tbl[i].ack_after) begin
        pulse_ack;
        check_out($sformatf("vec%0d ack", i), tbl[i].exp_data, 1'b0, 1'b0, 1'b0);
      end
      idle(4);
    end

    // Reset during data bit 4 of 0xFF.
    ff_bits = {STOP_BIT, 8'hFF, START_BIT};
    for (int n = 0; n < 5 * S + S / 2; n++) begin
      @(negedge clk);
      ser = ff_bits[n / S];
    end
    @(negedge clk);
    rst_b = 1'b0;
    ser   = 1'b1;
    repeat (2) @(negedge clk);
    check_out("midframe reset", 8'h00, 1'b0, 1'b0, 1'b0);
    check("midframe reset state", 32'(dut.state), 32'(IDLE));
    rst_b = 1'b1;
    idle(4);
    send_frame(8'h81, 1'b1, 1'b0, 1'b0);
    check_out("after reset 81", 8'h81, 1'b1, 1'b0, 1'b0);
    pulse_ack;
    check_out("after reset 81 ack", 8'h81, 1'b0, 1'b0, 1'b0);
    idle(4);

    // Randomized frames against the model, some of them back to back.
    m_data = 8'h81;
    m_rnr  = 1'b0;
    m_e1   = 1'b0;
    m_e2   = 1'b0;
    for (int i = 0; i < 24; i++) begin
      d         = W'($urandom);
      stopv     = ($urandom_range(0, 3) != 0);
      ack_stop  = ($urandom_range(0, 2) == 0);
      ack_after = ($urandom_range(0, 2) == 0);
      send_frame(d, stopv, ack_stop, 1'b0);
      model_frame(d, stopv, ack_stop);
      check_out($sformatf("rand%0d", i), m_data, m_rnr, m_e1, m_e2);
      if (ack_after) begin
        pulse_ack;
        model_ack();
        check_out($sformatf("rand%0d ack", i), m_data, m_rnr, m_e1, m_e2);
      end
      // A low stop bit looks like a new start to the re-armed FSM, so let
      // that false start die out before the next frame.
      if (!stopv) idle(4);
      else idle($urandom_range(0, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
